// File: rtl/pp_boot_loader.sv
// rtl/pp_boot_loader.sv - framed boot stream loader writing instruction/data memory, then releasing core reset
// Optional BOOT_CHECKSUM_EN adds a per-frame checksum word and a sticky err flag.
module pp_boot_loader #(
  parameter int unsigned RUN_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic        wr_sel,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_rstb,
  output logic        boot_done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_HDR,
    S_ADDR,
    S_DATA,
`ifdef BOOT_CHECKSUM_EN
    S_CSUM,
`endif
    S_HOLD,
    S_RUN
  } state_t;

  state_t      state_q;
  logic        last_q;
  logic        tgt_q;
  logic [15:0] cnt_q;
  logic [31:0] base_q;
  logic [7:0]  hold_q;
  logic        in_ready_q;
  logic        wr_en_q;
  logic        wr_sel_q;
  logic [31:0] wr_addr_q;
  logic [31:0] wr_data_q;
  logic        core_rstb_q;
  logic        boot_done_q;
  logic        beat;
  logic        frame_end;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] sum_q;
  logic        err_q;
`endif

  assign beat = in_valid & in_ready_q;

  // A frame completes on its final accepted word (checksum word when enabled)
  always_comb begin
    frame_end = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    frame_end = beat && (state_q == S_CSUM) && (in_data == sum_q);
`else
    frame_end = beat && (((state_q == S_ADDR) && (cnt_q == 16'd0)) ||
                         ((state_q == S_DATA) && (cnt_q == 16'd1)));
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HDR;
      last_q      <= 1'b0;
      tgt_q       <= 1'b0;
      cnt_q       <= 16'd0;
      base_q      <= 32'd0;
      hold_q      <= 8'd0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= 1'b0;
      wr_addr_q   <= 32'd0;
      wr_data_q   <= 32'd0;
      core_rstb_q <= 1'b0;
      boot_done_q <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_q       <= 32'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_HDR: begin
          in_ready_q <= 1'b1;
          if (beat) begin
            last_q  <= in_data[31];
            tgt_q   <= in_data[30];
            cnt_q   <= in_data[15:0];
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (beat) begin
            base_q <= in_data;
`ifdef BOOT_CHECKSUM_EN
            sum_q   <= 32'd0;
            state_q <= (cnt_q == 16'd0) ? S_CSUM : S_DATA;
`else
            state_q <= S_DATA;
`endif
          end
        end
        S_DATA: begin
          if (beat) begin
            wr_en_q   <= 1'b1;
            wr_sel_q  <= tgt_q;
            wr_addr_q <= base_q;
            wr_data_q <= in_data;
            base_q    <= base_q + 32'd4;
            cnt_q     <= cnt_q - 16'd1;
`ifdef BOOT_CHECKSUM_EN
            sum_q <= sum_q + in_data;
            if (cnt_q == 16'd1) state_q <= S_CSUM;
`endif
          end
        end
`ifdef BOOT_CHECKSUM_EN
        S_CSUM: begin
          // A bad frame is dropped; the host may resend it from a fresh header
          if (beat && (in_data != sum_q)) begin
            err_q   <= 1'b1;
            state_q <= S_HDR;
          end
        end
`endif
        S_HOLD: begin
          if (hold_q == 8'd0) begin
            state_q     <= S_RUN;
            core_rstb_q <= 1'b1;
            boot_done_q <= 1'b1;
          end else begin
            hold_q <= hold_q - 8'd1;
          end
        end
        S_RUN: begin
          in_ready_q <= 1'b0;
        end
        default: state_q <= S_HDR;
      endcase
      if (frame_end) begin
        if (last_q) begin
          state_q    <= S_HOLD;
          in_ready_q <= 1'b0;
          hold_q     <= 8'(RUN_DELAY - 1);
        end else begin
          state_q <= S_HDR;
        end
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_sel    = wr_sel_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign core_rstb = core_rstb_q;
  assign boot_done = boot_done_q;
`ifdef BOOT_CHECKSUM_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/pp_boot_loader.md
PP_BOOT_LOADER -- requirements
Module: pp_boot_loader

Interface
REQ-001 SHALL have parameter RUN_DELAY, default 2: cycles core_rstb stays low after the last frame completes (range 1..255).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port in_data, input, 32: boot stream word.
REQ-005 SHALL have port in_valid, input, 1: in_data valid.
REQ-006 SHALL have port in_ready, output, 1: loader accepts a word; a beat is transferred when in_valid & in_ready.
REQ-007 SHALL have port wr_en, output, 1: one-cycle memory write strobe.
REQ-008 SHALL have port wr_sel, output, 1: write target, 0 = instruction memory, 1 = data memory.
REQ-009 SHALL have port wr_addr, output, 32: byte address of the write.
REQ-010 SHALL have port wr_data, output, 32: write word.
REQ-011 SHALL have port core_rstb, output, 1: active-low processor reset.
REQ-012 SHALL have port boot_done, output, 1: high once core_rstb has been released.
REQ-013 SHALL have port err, output, 1: sticky checksum error (Configuration only).

Function
REQ-014 SHALL parse frames in the form header, base address, N data words. Header bit31 = last frame, bit30 = target, bits[15:0] = N; other bits are ignored.
REQ-015 SHALL implement states S_HDR, S_ADDR, S_DATA, S_CSUM (macro only), S_HOLD and S_RUN.
REQ-016 SHALL drive in_ready=1 in S_HDR, S_ADDR, S_DATA and S_CSUM, and 0 in S_HOLD and S_RUN.
REQ-017 Transitions:
- S_HDR → S_ADDR on an accepted beat; the loader latches last, target and N.
- S_ADDR → S_DATA on an accepted beat when N>0; the loader latches the base address.
- S_ADDR → frame end when N=0.
- S_DATA decrements its remaining count per accepted beat and leaves after the Nth beat.
REQ-018 Frame end SHALL go to S_HOLD if last=1, else to S_HDR.
REQ-019 For each accepted data beat k (0-based), the loader SHALL assert wr_en for exactly one cycle on the next cycle, with:
- wr_addr = base + 4*k, modulo 2^32 (wraps from 0xFFFFFFFC to 0);
- wr_sel = target;
- wr_data = the beat.
REQ-020 wr_en SHALL be 0 in all other cycles; wr_addr, wr_sel and wr_data hold their last values when wr_en=0.
REQ-021 Back-to-back beats SHALL produce back-to-back writes with no bubble; throughput is 1 word/cycle.
REQ-022 S_HOLD SHALL count RUN_DELAY cycles with core_rstb=0, then enter S_RUN.
REQ-023 In S_RUN: core_rstb=1, boot_done=1, and in_valid is ignored; S_RUN persists until reset.
REQ-024 in_valid=0 at any point SHALL stall parsing without losing state.

Reset
REQ-025 While rst=1, the loader SHALL be in S_HDR with all outputs at reset values: in_ready=0, wr_en=0, wr_sel=0, wr_addr=0, wr_data=0, core_rstb=0, boot_done=0, err=0.
REQ-026 in_ready SHALL rise on the first clock edge after rst falls.
REQ-027 Reset asserted mid-frame or in S_RUN SHALL abort immediately: the current frame is discarded, no pending wr_en is issued, and core_rstb drops to 0 asynchronously.

Configuration
REQ-028 With macro BOOT_CHECKSUM_EN defined:
- each frame carries one extra word after its data, accepted in S_CSUM;
- the expected value is the 32-bit wrap-around sum of the frame's data words (0 when N=0);
- on a match, frame end proceeds per REQ-018;
- on a mismatch, err is set sticky, the state returns to S_HDR regardless of last, and core_rstb stays 0.
REQ-029 Without BOOT_CHECKSUM_EN: no S_CSUM state, no checksum word, and err is tied to 0.

Verification
REQ-030 Single frame: header 0x80000003, addr 0x00400000, data A,B,C. Required: writes to 0x00400000, 0x00400004, 0x00400008 with wr_sel=0 on consecutive cycles; core_rstb rises exactly RUN_DELAY=2 cycles after frame end.
REQ-031 Two frames: header 0x40000002 @0x10000000 with data 5,7, then header 0x80000001 @0x00400000. Required: first two writes have wr_sel=1, third has wr_sel=0; boot_done=1 only after the second frame.
REQ-032 Wrap and empty frame: header 0x00000002 @0xFFFFFFFC gives writes at 0xFFFFFFFC then 0x00000000. A following header 0x80000000 @any gives no write and enters S_HOLD.
REQ-033 Stall/reset: in_valid toggling 1-0-1 during data gives the same write sequence with gaps. rst pulsed after the second of 4 data words gives exactly 2 writes, then S_HDR and core_rstb=0.
REQ-034 BOOT_CHECKSUM_EN: frame 0x80000002 @0x0, data 1,2, checksum 3 leads to RUN with err=0. The same frame with checksum 4 gives err=1, core_rstb=0 and in_ready=1 (back in S_HDR).
